// File: rtl/aes_rkey_sched_if.sv
// Bus bundle for the AES-256 round-key scheduler: key input, expander link and shared read port.
interface aes_rkey_sched_if;
    logic [255:0] key_in;
    logic         key_valid;
    logic         exp_start;
    logic [255:0] exp_seed;
    logic         exp_valid;
    logic [255:0] exp_word;
    logic         keys_ready;
    logic         exp_err;
    logic         enc_req;
    logic [3:0]   enc_idx;
    logic         dec_req;
    logic [3:0]   dec_idx;
    logic         enc_gnt;
    logic         dec_gnt;
    logic [127:0] rk_out;
    logic         rk_valid;
    logic         rk_owner;
    logic         rk_err;

    // Scheduler side
    modport slave (
        input  key_in, key_valid, exp_valid, exp_word,
               enc_req, enc_idx, dec_req, dec_idx,
        output exp_start, exp_seed, keys_ready, exp_err,
               enc_gnt, dec_gnt, rk_out, rk_valid, rk_owner, rk_err
    );

    // Key source / expander / cipher-core side
    modport master (
        output key_in, key_valid, exp_valid, exp_word,
               enc_req, enc_idx, dec_req, dec_idx,
        input  exp_start, exp_seed, keys_ready, exp_err,
               enc_gnt, dec_gnt, rk_out, rk_valid, rk_owner, rk_err
    );
endinterface

// File: rtl/aes_rkey_sched.sv
// AES-256 round-key scheduler: requests one key expansion per re-key, stores the
// fifteen 128-bit round keys and serves them to the enc/dec engines through a
// round-robin arbitrated, registered read port.
module aes_rkey_sched #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned RK_W    = 128
) (
    input  logic             clk,
    input  logic             rst,
    aes_rkey_sched_if.slave  bus
);

    localparam int unsigned KEY_W = 2 * RK_W;
    localparam int unsigned N_RK  = 15;
    localparam int unsigned TW    = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_FILL  = 2'd2;
    localparam logic [1:0] S_READY = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [2:0]       wcnt_q, wcnt_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic             last_dec_q, last_dec_d;   // 1: dec was granted last, so enc is favoured
    logic [KEY_W-1:0] exp_seed_q, exp_seed_d;
    logic             exp_start_q, exp_start_d;
    logic             keys_ready_q, keys_ready_d;
    logic             exp_err_q, exp_err_d;
    logic [RK_W-1:0]  rk_q [N_RK];
    logic [RK_W-1:0]  rk_d [N_RK];
    logic             enc_gnt_q, enc_gnt_d;
    logic             dec_gnt_q, dec_gnt_d;
    logic             rd_pend_q, rd_pend_d;
    logic             rd_owner_q, rd_owner_d;
    logic [3:0]       rd_idx_q, rd_idx_d;
    logic [RK_W-1:0]  rk_out_q, rk_out_d;
    logic             rk_valid_q, rk_valid_d;
    logic             rk_owner_q, rk_owner_d;
    logic             rk_err_q, rk_err_d;

    // Next-state, key store writes, arbitration and read-data selection
    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        tmo_d        = tmo_q;
        last_dec_d   = last_dec_q;
        exp_seed_d   = exp_seed_q;
        exp_start_d  = 1'b0;
        keys_ready_d = keys_ready_q;
        exp_err_d    = exp_err_q;
        rk_d         = rk_q;
        enc_gnt_d    = 1'b0;
        dec_gnt_d    = 1'b0;
        rd_pend_d    = 1'b0;
        rd_owner_d   = rd_owner_q;
        rd_idx_d     = rd_idx_q;

        case (state_q)
            S_IDLE, S_READY: begin
                if (bus.key_valid) begin
                    exp_seed_d   = bus.key_in;
                    keys_ready_d = 1'b0;
                    exp_err_d    = 1'b0;
                    state_d      = S_LOAD;
                end else if (state_q == S_READY) begin
                    // Both requesting: serve the side not granted last
                    if (bus.enc_req && (!bus.dec_req || last_dec_q)) begin
                        enc_gnt_d  = 1'b1;
                        last_dec_d = 1'b0;
                        rd_pend_d  = 1'b1;
                        rd_owner_d = 1'b0;
                        rd_idx_d   = bus.enc_idx;
                    end else if (bus.dec_req) begin
                        dec_gnt_d  = 1'b1;
                        last_dec_d = 1'b1;
                        rd_pend_d  = 1'b1;
                        rd_owner_d = 1'b1;
                        rd_idx_d   = bus.dec_idx;
                    end
                end
            end
            S_LOAD: begin
                exp_start_d = 1'b1;
                wcnt_d      = 3'd0;
                tmo_d       = '0;
                state_d     = S_FILL;
            end
            S_FILL: begin
                if (bus.exp_valid) begin
                    tmo_d = '0;
                    rk_d[{wcnt_q, 1'b0}] = bus.exp_word[KEY_W-1:RK_W];
                    // The lower half of the last word would be a 16th key; drop it
                    if (wcnt_q != 3'd7) begin
                        rk_d[{wcnt_q, 1'b1}] = bus.exp_word[RK_W-1:0];
                        wcnt_d = wcnt_q + 3'd1;
                    end else begin
                        keys_ready_d = 1'b1;
                        state_d      = S_READY;
                    end
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    exp_err_d = 1'b1;
                    tmo_d     = '0;
                    state_d   = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        rk_valid_d = rd_pend_q;
        rk_owner_d = rd_pend_q & rd_owner_q;
        rk_err_d   = rd_pend_q && (rd_idx_q == 4'd15);
        rk_out_d   = '0;
        if (rd_pend_q && (rd_idx_q != 4'd15)) begin
            rk_out_d = rk_q[rd_idx_q];
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            wcnt_q       <= 3'd0;
            tmo_q        <= '0;
            last_dec_q   <= 1'b1;
            exp_seed_q   <= '0;
            exp_start_q  <= 1'b0;
            keys_ready_q <= 1'b0;
            exp_err_q    <= 1'b0;
            for (int i = 0; i < N_RK; i++) begin
                rk_q[i] <= '0;
            end
            enc_gnt_q    <= 1'b0;
            dec_gnt_q    <= 1'b0;
            rd_pend_q    <= 1'b0;
            rd_owner_q   <= 1'b0;
            rd_idx_q     <= 4'd0;
            rk_out_q     <= '0;
            rk_valid_q   <= 1'b0;
            rk_owner_q   <= 1'b0;
            rk_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            tmo_q        <= tmo_d;
            last_dec_q   <= last_dec_d;
            exp_seed_q   <= exp_seed_d;
            exp_start_q  <= exp_start_d;
            keys_ready_q <= keys_ready_d;
            exp_err_q    <= exp_err_d;
            rk_q         <= rk_d;
            enc_gnt_q    <= enc_gnt_d;
            dec_gnt_q    <= dec_gnt_d;
            rd_pend_q    <= rd_pend_d;
            rd_owner_q   <= rd_owner_d;
            rd_idx_q     <= rd_idx_d;
            rk_out_q     <= rk_out_d;
            rk_valid_q   <= rk_valid_d;
            rk_owner_q   <= rk_owner_d;
            rk_err_q     <= rk_err_d;
        end
    end

    assign bus.exp_start  = exp_start_q;
    assign bus.exp_seed   = exp_seed_q;
    assign bus.keys_ready = keys_ready_q;
    assign bus.exp_err    = exp_err_q;
    assign bus.enc_gnt    = enc_gnt_q;
    assign bus.dec_gnt    = dec_gnt_q;
    assign bus.rk_out     = rk_out_q;
    assign bus.rk_valid   = rk_valid_q;
    assign bus.rk_owner   = rk_owner_q;
    assign bus.rk_err     = rk_err_q;

endmodule

// File: doc/aes_rkey_sched.md
Name: aes_rkey_sched

Overview:
- Sequences the 256-bit key-expansion unit for an AES-256 engine.
- On a new cipher key, issues one expansion request, collects the eight 256-bit schedule words and splits them into fifteen 128-bit round keys.
- Shares the stored keys between the encrypt and decrypt round engines through a single round-robin-arbitrated read port.
- Sits between the key input registers, the expander and both cipher cores.

Parameters:
- TIMEOUT, 64: maximum idle cycles allowed between expander words before the fill is aborted.
- RK_W, 128: round-key width. Fixed for AES; other values are not supported.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- key_in  in  256  cipher key, sampled when key_valid=1.
- key_valid  in  1  one-cycle pulse requesting a re-key.
- exp_start  out  1  one-cycle pulse that starts the expander.
- exp_seed  out  256  key presented to the expander; held stable from exp_start until fill ends.
- exp_valid  in  1  exp_word qualifier.
- exp_word  in  256  schedule word; the first word is the seed itself.
- keys_ready  out  1  all 15 round keys stored.
- exp_err  out  1  sticky timeout flag; cleared by the next accepted key_valid.
- enc_req  in  1  encrypt engine read request.
- enc_idx  in  4  requested round index.
- dec_req  in  1  decrypt engine read request.
- dec_idx  in  4  requested round index.
- enc_gnt  out  1  one-cycle grant to the encrypt engine.
- dec_gnt  out  1  one-cycle grant to the decrypt engine.
- rk_out  out  128  round key.
- rk_valid  out  1  rk_out valid.
- rk_owner  out  1  requester of rk_out: 0 = enc, 1 = dec.
- rk_err  out  1  index >14 on this read.

Behaviour:
- Reset (rst=1 at a rising clk edge):
  - State IDLE; word counter 0; timeout counter 0; RR pointer favours enc.
  - All outputs 0. exp_seed is 0 and the key store is cleared to 0.
- FSM states: IDLE, LOAD, FILL, READY.
- IDLE or READY with key_valid=1:
  - Latch key_in into exp_seed.
  - Next state LOAD.
  - keys_ready and exp_err drop on the following cycle.
- LOAD: exp_start=1 for exactly one cycle, then FILL. Word counter and timeout counter are cleared.
- FILL, per exp_valid cycle:
  - Word w (0..7) is stored as: rk[2w] = exp_word[255:128], rk[2w+1] = exp_word[127:0].
  - For w=7 the lower half is discarded.
  - After word 7 is stored: next state READY and keys_ready=1 on the next cycle.
  - Total latency from the key_valid edge to keys_ready=1 is 3 cycles plus expander latency.
- FILL timeout:
  - The timeout counter increments on every cycle with exp_valid=0 and resets on exp_valid=1.
  - When it reaches TIMEOUT: exp_err=1, state IDLE, partial keys kept, keys_ready stays 0.
- Ignored inputs:
  - key_valid in LOAD or FILL is ignored, not queued.
  - exp_valid outside FILL is ignored.
  - Words beyond the eighth are never stored.
- Arbitration (READY only):
  - At most one grant per cycle.
  - Single request: grant it.
  - Both requesting: grant the requester not granted last, then update the pointer to the granted side.
  - Requesters hold req and idx until gnt.
  - No grants in any state other than READY; requests simply wait.
- Read path:
  - Registered: rk_valid, rk_out, rk_owner and rk_err appear the cycle after gnt and last one cycle.
  - idx 0..14 returns rk[idx] with rk_err=0.
  - idx 15 returns rk_out=0 with rk_err=1.
- Re-key while READY:
  - No grant is issued in the cycle key_valid is seen.
  - A read granted in the previous cycle still completes with the old key.
- Reset mid-FILL: returns to IDLE, and late exp_valid is ignored.

Test Plan:
1. Reset, then key_valid with key_in=000102…1f.
   - Required: exp_start pulses exactly once, 2 cycles after key_valid.
   - Required: exp_seed = 000102…1f.
   - Bench drives eight words from the FIPS-197 AES-256 schedule.
   - Required: keys_ready=1.
   - Required: rk[1]=101112131415161718191a1b1c1d1e1f, rk[2]=a573c29fa176c498a97fce93a572c09c, rk[14]=24fc79ccbf0979e9371ac23c6d68de36.
2. enc_req and dec_req held high for 4 cycles with enc_idx=0, dec_idx=14.
   - Required: grants alternate enc, dec, enc, dec.
   - Required: rk_owner and rk_out match each grant one cycle later.
3. dec_req with dec_idx=15.
   - Required: dec_gnt=1, then rk_valid=1, rk_err=1, rk_out=0.
4. FILL with exp_valid held low for 64 cycles after word 3.
   - Required: exp_err=1, state IDLE, keys_ready=0.
   - Next key_valid clears exp_err.
5. key_valid in READY while enc_req is pending.
   - Required: keys_ready drops and enc_gnt stays 0 through the refill.
   - Required: the grant resumes after the new keys_ready.
6. key_valid pulsed during FILL, and rst asserted mid-FILL.
   - Required: the key_valid pulse is ignored and only one exp_start is issued.
   - Required: rst returns all outputs to 0 on the next edge.
